// File: rtl/quat_link_pkg.sv
// Shared framing definitions for the quaternion byte link (decoder and uart_sender).
// Frame: HDR0, HDR1, q0 lo/hi, q1 lo/hi, q2 lo/hi, q3 lo/hi, XOR checksum of payload.
package quat_link_pkg;

  localparam logic [7:0] HDR0_DEF      = 8'hAA;
  localparam logic [7:0] HDR1_DEF      = 8'h55;
  localparam int         PAYLOAD_BYTES = 8;
  localparam int         IDX_W         = $clog2(PAYLOAD_BYTES);
  localparam int         NUM_COMP      = 4;

  // Byte order of one component inside the payload (little-endian)
  localparam int LO_OFS = 0;
  localparam int HI_OFS = 1;

  typedef enum logic [1:0] {
    ST_HUNT0   = 2'd0,
    ST_HUNT1   = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  typedef logic [PAYLOAD_BYTES-1:0][7:0] payload_t;

  typedef struct packed {
    logic signed [15:0] q3;
    logic signed [15:0] q2;
    logic signed [15:0] q1;
    logic signed [15:0] q0;
  } quat_t;

  function automatic logic [15:0] comp_word(input payload_t p, input int c);
    return {p[2*c+HI_OFS], p[2*c+LO_OFS]};
  endfunction

  function automatic quat_t unpack_payload(input payload_t p);
    quat_t q;
    q.q0 = comp_word(p, 0);
    q.q1 = comp_word(p, 1);
    q.q2 = comp_word(p, 2);
    q.q3 = comp_word(p, 3);
    return q;
  endfunction

endpackage

// File: rtl/quat_frame_decoder_if.sv
// Byte stream in, decoded quaternion and status pulses out.
// master = byte source / result consumer, slave = decoder.
interface quat_frame_decoder_if;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic signed [15:0] q0;
  logic signed [15:0] q1;
  logic signed [15:0] q2;
  logic signed [15:0] q3;
  logic               frame_valid;
  logic               chk_err;
  logic               timeout_err;

  modport master (
    output byte_in, byte_valid,
    input  q0, q1, q2, q3, frame_valid, chk_err, timeout_err
  );

  modport slave (
    input  byte_in, byte_valid,
    output q0, q1, q2, q3, frame_valid, chk_err, timeout_err
  );
endinterface

// File: rtl/idle_timeout_ctr.sv
// Counts idle cycles while enabled; expired flags the cycle the count would reach
// TIMEOUT_CYC with no kick. A kick in that same cycle wins and clears the count.
module idle_timeout_ctr #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expired = enable && !kick && (cnt_q == LAST);
    cnt_d   = cnt_q + CW'(1);
    if (!enable || kick || expired) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/quat_frame_decoder.sv
// Sync-hunting frame decoder: AA 55 + 8 payload bytes + XOR checksum -> q0..q3.
// Payload is staged separately so bad or abandoned frames never touch the outputs.
module quat_frame_decoder
  import quat_link_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF
) (
  input  logic              clk,
  input  logic              rst,
  quat_frame_decoder_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  payload_t         stage_q, stage_d;
  quat_t            quat_q, quat_d;
  logic             frame_valid_q, frame_valid_d;
  logic             chk_err_q, chk_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             expired;
  logic             bv;
  logic [7:0]       b;

  assign bv = bus.byte_valid;
  assign b  = bus.byte_in;

  idle_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q != ST_HUNT0),
    .kick    (bv),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_HUNT0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (expired) begin
      state_d = ST_HUNT0;
    end else if (bv) begin
      unique case (state_q)
        ST_HUNT0:   if (b == HDR0) state_d = ST_HUNT1;
        // A repeated HDR0 may itself be the start of the real header
        ST_HUNT1:   if (b == HDR1)      state_d = ST_PAYLOAD;
                    else if (b != HDR0) state_d = ST_HUNT0;
        ST_PAYLOAD: if (idx_q == LAST_IDX) state_d = ST_CHECK;
        ST_CHECK:   state_d = ST_HUNT0;
        default:    state_d = ST_HUNT0;
      endcase
    end
  end

  always_comb begin
    idx_d         = idx_q;
    chk_d         = chk_q;
    stage_d       = stage_q;
    quat_d        = quat_q;
    frame_valid_d = 1'b0;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    if (expired) begin
      idx_d         = '0;
      chk_d         = '0;
      stage_d       = '0;
      timeout_err_d = 1'b1;
    end else if (bv) begin
      unique case (state_q)
        ST_HUNT1: begin
          if (b == HDR1) begin
            idx_d = '0;
            chk_d = '0;
          end
        end
        ST_PAYLOAD: begin
          stage_d[idx_q] = b;
          chk_d          = chk_q ^ b;
          idx_d          = idx_q + IDX_W'(1);
        end
        ST_CHECK: begin
          if (b == chk_q) begin
            quat_d        = unpack_payload(stage_q);
            frame_valid_d = 1'b1;
          end else begin
            chk_err_d     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q         <= '0;
      chk_q         <= '0;
      stage_q       <= '0;
      quat_q        <= '0;
      frame_valid_q <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      stage_q       <= stage_d;
      quat_q        <= quat_d;
      frame_valid_q <= frame_valid_d;
      chk_err_q     <= chk_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.q0          = quat_q.q0;
  assign bus.q1          = quat_q.q1;
  assign bus.q2          = quat_q.q2;
  assign bus.q3          = quat_q.q3;
  assign bus.frame_valid = frame_valid_q;
  assign bus.chk_err     = chk_err_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_quat_frame_decoder.sv
// Self-checking bench for quat_frame_decoder: directed frames from the test plan plus
// randomized framed traffic checked against a frame-level model (last good quaternion).
module tb_quat_frame_decoder;
  import quat_link_pkg::*;

  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quat_frame_decoder_if bus();

  quat_frame_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        s_fv, s_ce, s_te;
  logic [15:0] s_q[4];
  logic [15:0] exp_q[4];
  int          pulses;

  // One cycle: sample the result of the previous edge, then drive the next edge's input
  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    s_fv = bus.frame_valid;
    s_ce = bus.chk_err;
    s_te = bus.timeout_err;
    s_q[0] = bus.q0; s_q[1] = bus.q1; s_q[2] = bus.q2; s_q[3] = bus.q3;
    pulses += int'(s_fv) + int'(s_ce) + int'(s_te);
    bus.byte_valid = v;
    bus.byte_in    = v ? b : 8'h00;
  endtask

  function automatic logic [7:0] xor8(input logic [15:0] w[4]);
    logic [7:0] x;
    x = 8'h00;
    for (int c = 0; c < 4; c++) x = x ^ w[c][7:0] ^ w[c][15:8];
    return x;
  endfunction

  task automatic gap(input int maxgap);
    int n;
    n = int'($urandom_range(maxgap, 0));
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [15:0] w[4], input logic [7:0] chk, input int maxgap);
    pulses = 0;
    step(1'b1, HDR0_DEF); gap(maxgap);
    step(1'b1, HDR1_DEF);
    for (int c = 0; c < 4; c++) begin
      gap(maxgap); step(1'b1, w[c][7:0]);
      gap(maxgap); step(1'b1, w[c][15:8]);
    end
    gap(maxgap); step(1'b1, chk);
  endtask

  task automatic test_reset();
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    rst = 1'b1;
    pulses = 0;
    repeat (3) step(1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (s_q[c] !== 16'h0000) begin
        n_fail++; $display("FAIL reset_q%0d: got %h exp 0000", c, s_q[c]);
      end
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL reset_pulses: got %0d exp 0", pulses);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) exp_q[c] = 16'h0000;
  endtask

  task automatic test_good_frame();
    logic [15:0] w[4];
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    send_frame(w, xor8(w), 0);
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL good_early_pulse: got %0d exp 0", pulses); end
    step(1'b0, 8'h00);
    exp_q = w;
    n_tests++;
    if ({s_fv, s_ce, s_te} !== 3'b100) begin
      n_fail++; $display("FAIL good_pulses fv/ce/te: got %b exp 100", {s_fv, s_ce, s_te});
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (s_q[c] !== exp_q[c]) begin
        n_fail++; $display("FAIL good_q%0d: got %h exp %h", c, s_q[c], exp_q[c]);
      end
    end
    step(1'b0, 8'h00);
    n_tests++;
    if (s_fv !== 1'b0) begin n_fail++; $display("FAIL good_fv_width: got %b exp 0", s_fv); end
  endtask

  task automatic test_bad_chk();
    logic [15:0] w[4];
    w = '{16'h0005, 16'h0000, 16'h0000, 16'h0000};
    send_frame(w, xor8(w) ^ 8'h03, 0);
    step(1'b0, 8'h00);
    n_tests++;
    if ({s_fv, s_ce, s_te} !== 3'b010) begin
      n_fail++; $display("FAIL badchk_pulses fv/ce/te: got %b exp 010", {s_fv, s_ce, s_te});
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (s_q[c] !== exp_q[c]) begin
        n_fail++; $display("FAIL badchk_q%0d: got %h exp %h", c, s_q[c], exp_q[c]);
      end
    end
    step(1'b0, 8'h00);
    n_tests++;
    if (s_ce !== 1'b0) begin n_fail++; $display("FAIL badchk_ce_width: got %b exp 0", s_ce); end
  endtask

  task automatic test_negative();
    logic [15:0] w[4];
    w = '{16'hFFFF, 16'h8000, 16'h55AA, 16'h1234};
    send_frame(w, xor8(w), 1);
    step(1'b0, 8'h00);
    exp_q = w;
    n_tests++;
    if ({s_fv, s_ce, s_te} !== 3'b100 || pulses != 1) begin
      n_fail++; $display("FAIL neg_pulses fv/ce/te: got %b (total %0d) exp 100 (total 1)",
                         {s_fv, s_ce, s_te}, pulses);
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (s_q[c] !== exp_q[c]) begin
        n_fail++; $display("FAIL neg_q%0d: got %h exp %h", c, s_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_resync();
    logic [15:0] w[4];
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    step(1'b1, 8'h00);
    step(1'b1, HDR0_DEF);
    send_frame(w, xor8(w), 0);
    step(1'b0, 8'h00);
    exp_q = w;
    n_tests++;
    if ({s_fv, s_ce, s_te} !== 3'b100) begin
      n_fail++; $display("FAIL resync_pulses fv/ce/te: got %b exp 100", {s_fv, s_ce, s_te});
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (s_q[c] !== exp_q[c]) begin
        n_fail++; $display("FAIL resync_q%0d: got %h exp %h", c, s_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] w[4];
    int tcyc, te_cnt, other;
    tcyc = -1; te_cnt = 0; other = 0;
    step(1'b1, HDR0_DEF); step(1'b1, HDR1_DEF);
    step(1'b1, 8'h01);    step(1'b1, 8'h00);
    for (int k = 1; k <= TO + 20; k++) begin
      step(1'b0, 8'h00);
      if (s_te) begin
        te_cnt++;
        if (tcyc < 0) tcyc = k - 1;
      end
      if (s_fv || s_ce) other++;
    end
    n_tests++;
    if (tcyc != TO) begin n_fail++; $display("FAIL timeout_cycle: got %0d exp %0d", tcyc, TO); end
    n_tests++;
    if (te_cnt != 1 || other != 0) begin
      n_fail++; $display("FAIL timeout_pulse_count: got te=%0d other=%0d exp te=1 other=0", te_cnt, other);
    end
    for (int c = 0; c < 4; c++) w[c] = 16'($urandom);
    send_frame(w, xor8(w), 2);
    step(1'b0, 8'h00);
    exp_q = w;
    n_tests++;
    if ({s_fv, s_ce, s_te} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_recover fv/ce/te: got %b exp 100", {s_fv, s_ce, s_te});
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (s_q[c] !== exp_q[c]) begin
        n_fail++; $display("FAIL timeout_recover_q%0d: got %h exp %h", c, s_q[c], exp_q[c]);
      end
    end
  endtask

  // Byte lands in exactly the cycle the idle count would expire: the byte must win
  task automatic test_expiry_vs_byte();
    logic [15:0] w[4];
    for (int c = 0; c < 4; c++) w[c] = 16'($urandom);
    pulses = 0;
    step(1'b1, HDR0_DEF); step(1'b1, HDR1_DEF);
    repeat (TO - 1) step(1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, w[c][7:0]); step(1'b1, w[c][15:8]);
    end
    step(1'b1, xor8(w));
    step(1'b0, 8'h00);
    exp_q = w;
    n_tests++;
    if (s_fv !== 1'b1 || pulses != 1) begin
      n_fail++; $display("FAIL expiry_vs_byte: got fv=%b pulses=%0d exp fv=1 pulses=1", s_fv, pulses);
    end
    n_tests++;
    if (s_q[3] !== exp_q[3]) begin
      n_fail++; $display("FAIL expiry_vs_byte_q3: got %h exp %h", s_q[3], exp_q[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w[4];
    step(1'b1, HDR0_DEF); step(1'b1, HDR1_DEF);
    step(1'b1, 8'h01); step(1'b1, 8'h00); step(1'b1, 8'h02);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    #1;
    n_tests++;
    if ({bus.q0, bus.q1, bus.q2, bus.q3} !== 64'h0 ||
        {bus.frame_valid, bus.chk_err, bus.timeout_err} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset_outputs: got q=%h%h%h%h pulses=%b exp all 0",
                         bus.q3, bus.q2, bus.q1, bus.q0,
                         {bus.frame_valid, bus.chk_err, bus.timeout_err});
    end
    for (int c = 0; c < 4; c++) exp_q[c] = 16'h0000;
    repeat (2) step(1'b0, 8'h00);
    rst = 1'b0;
    pulses = 0;
    step(1'b1, 8'h03); step(1'b1, 8'h00); step(1'b1, 8'h04);
    step(1'b1, 8'h00); step(1'b1, 8'h04);
    repeat (3) step(1'b0, 8'h00);
    n_tests++;
    if (pulses != 0 || s_q[0] !== 16'h0000) begin
      n_fail++; $display("FAIL reset_tail_ignored: got pulses=%0d q0=%h exp 0 and 0000", pulses, s_q[0]);
    end
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    send_frame(w, xor8(w), 0);
    step(1'b0, 8'h00);
    exp_q = w;
    n_tests++;
    if (s_fv !== 1'b1 || s_q[1] !== exp_q[1]) begin
      n_fail++; $display("FAIL reset_then_good: got fv=%b q1=%h exp fv=1 q1=%h", s_fv, s_q[1], exp_q[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wa[4], wb[4];
    logic [7:0]  q[$];
    for (int c = 0; c < 4; c++) begin wa[c] = 16'($urandom); wb[c] = 16'($urandom); end
    q = {};
    q.push_back(HDR0_DEF); q.push_back(HDR1_DEF);
    for (int c = 0; c < 4; c++) begin q.push_back(wa[c][7:0]); q.push_back(wa[c][15:8]); end
    q.push_back(xor8(wa));
    q.push_back(HDR0_DEF); q.push_back(HDR1_DEF);
    for (int c = 0; c < 4; c++) begin q.push_back(wb[c][7:0]); q.push_back(wb[c][15:8]); end
    q.push_back(xor8(wb));
    pulses = 0;
    for (int i = 0; i <= 22; i++) begin
      step(i < 22, (i < 22) ? q[i] : 8'h00);
      if (i == 11) begin
        n_tests++;
        if (s_fv !== 1'b1 || s_q[0] !== wa[0] || s_q[3] !== wa[3]) begin
          n_fail++; $display("FAIL b2b_first: got fv=%b q0=%h q3=%h exp 1 %h %h",
                             s_fv, s_q[0], s_q[3], wa[0], wa[3]);
        end
      end
    end
    exp_q = wb;
    n_tests++;
    if (s_fv !== 1'b1 || pulses != 2) begin
      n_fail++; $display("FAIL b2b_second: got fv=%b pulses=%0d exp 1 and 2", s_fv, pulses);
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (s_q[c] !== exp_q[c]) begin
        n_fail++; $display("FAIL b2b_q%0d: got %h exp %h", c, s_q[c], exp_q[c]);
      end
    end
  endtask

  // Random garbage (never 0x55, so it cannot open a frame), random gaps, random corruption
  task automatic test_random();
    logic [15:0] w[4];
    logic [7:0]  g, chk;
    logic        bad;
    int          ng;
    for (int f = 0; f < 30; f++) begin
      ng = int'($urandom_range(3, 0));
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom);
        if (g == HDR1_DEF) g = 8'h00;
        step(1'b1, g);
      end
      for (int c = 0; c < 4; c++) w[c] = 16'($urandom);
      bad = ($urandom_range(3, 0) == 0);
      chk = bad ? (xor8(w) ^ 8'($urandom_range(255, 1))) : xor8(w);
      send_frame(w, chk, 2);
      step(1'b0, 8'h00);
      if (!bad) exp_q = w;
      n_tests++;
      if ({s_fv, s_ce, s_te} !== {!bad, bad, 1'b0} || pulses != 1) begin
        n_fail++; $display("FAIL rand%0d_pulses fv/ce/te: got %b (total %0d) exp %b (total 1)",
                           f, {s_fv, s_ce, s_te}, pulses, {!bad, bad, 1'b0});
      end
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if (s_q[c] !== exp_q[c]) begin
          n_fail++; $display("FAIL rand%0d_q%0d: got %h exp %h", f, c, s_q[c], exp_q[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_negative();
    test_resync();
    test_timeout();
    test_expiry_vs_byte();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
